// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes and per-format field positions/shifts for the ARM immediate extender
package imm_pkg;
  typedef enum logic [2:0] {
    FMT_D  = 3'd0,
    FMT_I  = 3'd1,
    FMT_B  = 3'd2,
    FMT_CB = 3'd3,
    FMT_IW = 3'd4
  } imm_fmt_t;
  localparam int D_HI = 20;
  localparam int D_LO = 12;
  localparam int I_HI = 21;
  localparam int I_LO = 10;
  localparam int B_HI = 25;
  localparam int B_LO = 0;
  localparam int B_SH = 2;
  localparam int CB_HI = 23;
  localparam int CB_LO = 5;
  localparam int CB_SH = 2;
  localparam int IW_HI = 20;
  localparam int IW_LO = 5;
  localparam int IW_HW_HI = 22;
  localparam int IW_HW_LO = 21;
endpackage

// File: rtl/imm_field_extract.sv
// imm_field_extract: combinational (instr[31:0], fmt[2:0]) -> imm[WIDTH_OUT-1:0] extended/shifted immediate, err for illegal fmt
module imm_field_extract
  import imm_pkg::*;
#(
  parameter int WIDTH_OUT = 64
) (
  input  logic [31:0]          instr,
  input  logic [2:0]           fmt,
  output logic [WIDTH_OUT-1:0] imm,
  output logic                 err
);
  logic [WIDTH_OUT-1:0] d_ext, i_ext, b_ext, cb_ext, iw_ext;
  logic unused_bits;
  assign unused_bits = ^instr[31:26];
  assign d_ext  = WIDTH_OUT'($signed(instr[D_HI:D_LO]));
  assign i_ext  = WIDTH_OUT'(instr[I_HI:I_LO]);
  assign b_ext  = WIDTH_OUT'($signed(instr[B_HI:B_LO])) << B_SH;
  assign cb_ext = WIDTH_OUT'($signed(instr[CB_HI:CB_LO])) << CB_SH;
  assign iw_ext = WIDTH_OUT'(instr[IW_HI:IW_LO]) << {instr[IW_HW_HI:IW_HW_LO], 4'b0};
  always_comb begin
    err = fmt > 3'(FMT_IW);
    imm = fmt == 3'(FMT_D)  ? d_ext  :
          fmt == 3'(FMT_I)  ? i_ext  :
          fmt == 3'(FMT_B)  ? b_ext  :
          fmt == 3'(FMT_CB) ? cb_ext :
          fmt == 3'(FMT_IW) ? iw_ext : '0;
  end
endmodule

// File: rtl/imm_extend_arbiter.sv
// imm_extend_arbiter: round-robin 2-requester (req_valid/req_ready, instrN, fmtN) immediate extender with registered out_valid/out_ready result (out_imm, out_src, out_err)
module imm_extend_arbiter
  import imm_pkg::*;
#(
  parameter int WIDTH_OUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [31:0]          instr0,
  input  logic [31:0]          instr1,
  input  logic [2:0]           fmt0,
  input  logic [2:0]           fmt1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out_imm,
  output logic                 out_src,
  output logic                 out_err
);
  logic                 last_grant;
  logic                 slot_free;
  logic [1:0]           grant;
  logic                 sel;
  logic [WIDTH_OUT-1:0] imm;
  logic                 err;
  assign slot_free = !out_valid || out_ready;
  // last_grant holds the index of the previous winner; on conflict the other one wins
  assign grant = req_valid == 2'b11 ? (last_grant ? 2'b01 : 2'b10) : req_valid;
  assign req_ready = slot_free && !reset ? grant : 2'b00;
  assign sel = req_ready[1];
  imm_field_extract #(.WIDTH_OUT(WIDTH_OUT)) u_extract (
    .instr (sel ? instr1 : instr0),
    .fmt   (sel ? fmt1 : fmt0),
    .imm   (imm),
    .err   (err)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_src    <= 1'b0;
      out_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (|req_ready) begin
      out_valid  <= 1'b1;
      out_imm    <= imm;
      out_src    <= sel;
      out_err    <= err;
      last_grant <= sel;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imm_extend_arbiter.sv
// tb_imm_extend_arbiter: scoreboard bench with a behavioural immediate model and arbitration reference
module tb_imm_extend_arbiter;
  typedef struct packed {
    logic [63:0] imm;
    logic        src;
    logic        err;
  } exp_t;
  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] instr0, instr1;
  logic [2:0]  fmt0, fmt1;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic        out_src;
  logic        out_err;
  exp_t        q[$];
  exp_t        pend[2];
  int          checks = 0;
  int          errors = 0;
  int          wcnt[2];
  logic        mvalid = 1'b0;
  logic        prefer = 1'b0;
  logic        mon_en = 1'b0;

  imm_extend_arbiter #(.WIDTH_OUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .instr0    (instr0),
    .instr1    (instr1),
    .fmt0      (fmt0),
    .fmt1      (fmt1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_src   (out_src),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sext(input longint x, input int n);
    return x >= (longint'(1) <<< (n - 1)) ? x - (longint'(1) <<< n) : x;
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [2:0] f, input logic r);
    exp_t   e;
    longint x;
    longint u;
    u = longint'(i);
    e.err = 1'b0;
    case (f)
      3'd0: x = sext((u / 4096) % 512, 9);
      3'd1: x = (u / 1024) % 4096;
      3'd2: x = sext(u % 67108864, 26) * 4;
      3'd3: x = sext((u / 32) % 524288, 19) * 4;
      3'd4: x = ((u / 32) % 65536) * (longint'(1) <<< (16 * ((u / 2097152) % 4)));
      default: begin x = 0; e.err = 1'b1; end
    endcase
    e.imm = 64'(x);
    e.src = r;
    return e;
  endfunction

  task automatic drive(input int r, input logic [31:0] i, input logic [2:0] f);
    if (r == 0) begin instr0 = i; fmt0 = f; end
    else begin instr1 = i; fmt1 = f; end
    req_valid[r] = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [31:0] i, input logic [2:0] f);
    pend[r] = model(i, f, 1'(r));
    drive(r, i, f);
  endtask

  task automatic set_req_exp(input int r, input logic [31:0] i, input logic [2:0] f,
                             input logic [63:0] imm, input logic err);
    pend[r] = '{imm: imm, src: 1'(r), err: err};
    drive(r, i, f);
  endtask

  task automatic set_rand(input int r);
    set_req(r, $urandom, 3'($urandom_range(0, 7)));
  endtask

  task automatic step();
    logic [1:0] g, er;
    logic       ms, k;
    @(negedge clk);
    ms = !mvalid || out_ready;
    g = req_valid == 2'b11 ? (prefer ? 2'b10 : 2'b01) : req_valid;
    er = ms ? g : 2'b00;
    k = er[1];
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL req_ready got %b exp %b t=%0t", req_ready, er, $time);
    end
    for (int r = 0; r < 2; r++) begin
      if (req_valid[r] && ms) begin
        if (er[r]) wcnt[r] = 0;
        else begin
          wcnt[r]++;
          checks++;
          if (wcnt[r] > 1) begin
            errors++;
            $display("FAIL starve req%0d waited %0d slot-free cycles exp <=1", r, wcnt[r]);
          end
        end
      end
    end
    @(posedge clk);
    if (er != 2'b00) begin
      q.push_back(pend[k]);
      prefer = !k;
      mvalid = 1'b1;
    end else if (mvalid && out_ready) mvalid = 1'b0;
    #1;
    if (er != 2'b00) req_valid[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid got %b exp %b t=%0t", out_valid, q.size() != 0, $time);
      end
      if (out_valid && q.size() != 0) begin
        checks++;
        if ({out_imm, out_src, out_err} !== q[0]) begin
          errors++;
          $display("FAIL result got imm=%h src=%b err=%b exp imm=%h src=%b err=%b t=%0t",
                   out_imm, out_src, out_err, q[0].imm, q[0].src, q[0].err, $time);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  initial begin
    wcnt[0] = 0;
    wcnt[1] = 0;
    reset = 1'b1;
    out_ready = 1'b0;
    req_valid = 2'b11;
    instr0 = $urandom;
    instr1 = $urandom;
    fmt0 = 3'd1;
    fmt1 = 3'd2;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    out_ready = 1'b1;
    set_req_exp(0, 32'h1F0 << 12, 3'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    step();
    set_req_exp(0, 32'hFFF << 10, 3'd1, 64'h0000_0000_0000_0FFF, 1'b0);
    step();
    set_req_exp(0, 32'h03FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step();
    set_req_exp(1, (32'hBEEF << 5) | (32'h2 << 21), 3'd4, 64'h0000_BEEF_0000_0000, 1'b0);
    step();
    set_req_exp(1, $urandom, 3'd6, 64'd0, 1'b1);
    step();
    set_req(0, $urandom, 3'd3);
    step();
    step();
    out_ready = 1'b0;
    set_rand(0);
    set_rand(1);
    step();
    step();
    step();
    step();
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      if (!req_valid[0]) set_rand(0);
      if (!req_valid[1]) set_rand(1);
    end
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_req_ready", 64'(req_ready), 64'd0);
    q.delete();
    mvalid = 1'b0;
    prefer = 1'b0;
    wcnt[0] = 0;
    wcnt[1] = 0;
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      if (!req_valid[0]) set_rand(0);
      if (!req_valid[1]) set_rand(1);
    end
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 2; r++)
        if (!req_valid[r] && $urandom_range(0, 1) == 1) set_rand(r);
      step();
    end
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) step();
    chk("drain_queue", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
